// File: rtl/msk_rnd_pkg.sv
// msk_rnd_pkg
// Shared definitions for the masking randomness feeder: LFSR geometry and
// feedback taps, seed word width, and the feeder FSM state encoding.
package msk_rnd_pkg;

  localparam int LFSR_W = 64;
  localparam int SEED_W = 32;

  // Galois right-shift feedback mask for x^64 + x^63 + x^61 + x^60 + 1.
  // The bit position for a term x^k is k-1, so the taps land on bits 63, 62, 60 and 59.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEED_LO  = 2'd1,
    SEED_HI  = 2'd2,
    RUN      = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/msk_lfsr_step.sv
// msk_lfsr_step
// Combinational STEPS-step unrolled advance of the 64-bit Galois LFSR.
// Ports:
//   state_i  current LFSR state
//   state_o  state after STEPS shifts
//   bits_o   bits shifted out of LFSR bit 0, first shifted bit in bits_o[0]
module msk_lfsr_step
  import msk_rnd_pkg::*;
#(
  parameter int STEPS = 2
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [STEPS-1:0]  bits_o
);

  logic [LFSR_W-1:0] acc;

  always_comb begin
    acc    = state_i;
    bits_o = '0;
    for (int i = 0; i < STEPS; i++) begin
      bits_o[i] = acc[0];
      acc       = (acc >> 1) ^ (acc[0] ? LFSR_TAPS : '0);
    end
    state_o = acc;
  end

endmodule

// File: rtl/msk_rnd_feeder.sv
// msk_rnd_feeder
// Feeds fresh randomness to NG parallel HPC3 AND gadgets of d shares each.
// A 64-bit Galois LFSR is seeded with two 32-bit beats (low word first) and
// then advanced RW steps per transfer. The bits shifted out form rnd_out.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   seed_in/valid/ready   seed word handshake
//   rnd_out/valid/ready   randomness handshake, one transfer per cycle at most
//   busy                  high whenever the FSM is not in RUN
//   words_out             saturating count of completed transfers
//
// state    | meaning
// UNSEEDED | waiting for the low seed word after reset or a zero seed
// SEED_LO  | waiting for the low seed word after a reseed request
// SEED_HI  | waiting for the high seed word
// RUN      | producing randomness; rnd_valid low only on the priming cycle
module msk_rnd_feeder
  import msk_rnd_pkg::*;
#(
  parameter  int d  = 2,
  parameter  int NG = 1,
  localparam int RW = NG * d * (d - 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  output logic [RW-1:0]     rnd_out,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic [31:0]       words_out
);

  fsm_state_e        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [RW-1:0]     rnd_q, rnd_d;
  logic              valid_q, valid_d;
  logic [31:0]       words_q, words_d;

  logic [LFSR_W-1:0] lfsr_adv;
  logic [RW-1:0]     bits_adv;
  logic              seed_ready_c;
  logic              xfer;
  logic [LFSR_W-1:0] seed_full;

  msk_lfsr_step #(.STEPS(RW)) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_adv),
    .bits_o  (bits_adv)
  );

  assign xfer      = valid_q && rnd_ready;
  assign seed_full = {seed_in, lfsr_q[SEED_W-1:0]};

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    rnd_d        = rnd_q;
    valid_d      = valid_q;
    words_d      = words_q;
    seed_ready_c = 1'b0;

    case (state_q)
      UNSEEDED, SEED_LO: begin
        seed_ready_c = 1'b1;
        valid_d      = 1'b0;
        rnd_d        = '0;
        if (seed_valid) begin
          lfsr_d  = {lfsr_q[LFSR_W-1:SEED_W], seed_in};
          state_d = SEED_HI;
        end
      end
      SEED_HI: begin
        seed_ready_c = 1'b1;
        if (seed_valid) begin
          lfsr_d  = seed_full;
          // An all-zero state would lock the LFSR, so it is refused.
          state_d = (|seed_full) ? RUN : UNSEEDED;
        end
      end
      RUN: begin
        // Advance either to prime the first word or to replace a consumed one.
        if (!valid_q || xfer) begin
          lfsr_d  = lfsr_adv;
          rnd_d   = bits_adv;
          valid_d = 1'b1;
        end
        if (xfer && (words_q != 32'hFFFF_FFFF)) begin
          words_d = words_q + 32'd1;
        end
        // Reseed request wins: any transfer this cycle still counts, but the
        // output is withdrawn and the beat is left for SEED_LO to accept.
        if (seed_valid) begin
          state_d = SEED_LO;
          valid_d = 1'b0;
          rnd_d   = '0;
        end
      end
      default: begin
        state_d = UNSEEDED;
        valid_d = 1'b0;
        rnd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNSEEDED;
      lfsr_q  <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      words_q <= words_d;
    end
  end

  // Gating with rst_n keeps the seed port closed and busy asserted during the
  // reset cycle itself, not just after the reset edge.
  assign seed_ready = rst_n && seed_ready_c;
  assign busy       = !rst_n || (state_q != RUN);
  assign rnd_out    = rnd_q;
  assign rnd_valid  = valid_q;
  assign words_out  = words_q;

endmodule

// File: tb/tb_msk_rnd_feeder.sv
// tb_msk_rnd_feeder
// Self-checking bench for msk_rnd_feeder with d=2, NG=3 (6 bits per transfer).
// The reference model produces the LFSR output one bit at a time and groups
// the bits into transfer words.
module tb_msk_rnd_feeder;

  localparam int D  = 2;
  localparam int NG = 3;
  localparam int RW = NG * D * (D - 1);

  logic          clk;
  logic          rst_n;
  logic [31:0]   seed_in;
  logic          seed_valid;
  logic          seed_ready;
  logic [RW-1:0] rnd_out;
  logic          rnd_valid;
  logic          rnd_ready;
  logic          busy;
  logic [31:0]   words_out;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [63:0]   m_lfsr;
  logic [RW-1:0] m_word;
  logic [31:0]   m_words;

  msk_rnd_feeder #(.d(D), .NG(NG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .busy       (busy),
    .words_out  (words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference generator: one output bit is the low state bit, and the
  // polynomial x^64+x^63+x^61+x^60+1 feeds back into the shifted state.
  task automatic draw_word();
    logic b;
    for (int i = 0; i < RW; i++) begin
      b         = m_lfsr[0];
      m_word[i] = b;
      m_lfsr    = m_lfsr >> 1;
      if (b) m_lfsr = m_lfsr ^ ((64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59));
    end
  endtask

  task automatic count_xfer();
    if (m_words != 32'hFFFF_FFFF) m_words = m_words + 32'd1;
  endtask

  task automatic send_beat(input logic [31:0] w);
    bit ok;
    ok         = 1'b0;
    seed_valid = 1'b1;
    seed_in    = w;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (seed_ready) ok = 1'b1;
      @(negedge clk);
    end
    seed_valid = 1'b0;
    chk("seed_beat_accepted", 64'(ok), 64'd1);
  endtask

  task automatic expect_first_word(input logic [31:0] lo, input logic [31:0] hi);
    m_lfsr = {hi, lo};
    draw_word();
    chk("prime_valid_low", 64'(rnd_valid), 64'd0);
    chk("prime_busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    chk("first_valid", 64'(rnd_valid), 64'd1);
    chk("first_word", 64'(rnd_out), 64'(m_word));
  endtask

  task automatic run_stream(input int n);
    bit hs;
    for (int i = 0; i < n; i++) begin
      chk("stream_valid", 64'(rnd_valid), 64'd1);
      if (rnd_valid) chk("stream_word", 64'(rnd_out), 64'(m_word));
      chk("stream_words", 64'(words_out), 64'(m_words));
      rnd_ready = 1'($urandom % 2);
      hs = rnd_valid && rnd_ready;
      @(negedge clk);
      if (hs) begin
        count_xfer();
        draw_word();
      end
    end
    rnd_ready = 1'b0;
  endtask

  initial begin
    int c0;
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed_in    = '0;
    rnd_ready  = 1'b0;
    m_lfsr     = '0;
    m_word     = '0;
    m_words    = '0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(rnd_valid), 64'd0);
    chk("rst_rnd_out", 64'(rnd_out), 64'd0);
    chk("rst_words", 64'(words_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_seed_ready", 64'(seed_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_seed_ready", 64'(seed_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd1);

    // Seed 1 / 0 and check first output latency
    send_beat(32'h0000_0001);
    send_beat(32'h0000_0000);
    expect_first_word(32'h0000_0001, 32'h0000_0000);

    // Random backpressure stream
    run_stream(1000);

    // Reseed request coinciding with a transfer
    chk("pre_reseed_word", 64'(rnd_out), 64'(m_word));
    rnd_ready  = 1'b1;
    seed_valid = 1'b1;
    seed_in    = 32'hCAFE_1234;
    @(negedge clk);
    count_xfer();
    rnd_ready = 1'b0;
    chk("reseed_counted", 64'(words_out), 64'(m_words));
    chk("reseed_valid_low", 64'(rnd_valid), 64'd0);
    chk("reseed_rnd_zero", 64'(rnd_out), 64'd0);
    chk("reseed_busy", 64'(busy), 64'd1);
    c0 = cyc_cnt;
    send_beat(32'hCAFE_1234);
    send_beat(32'h0F0F_5A5A);
    chk("reseed_two_beats", 64'(cyc_cnt - c0), 64'd2);
    expect_first_word(32'hCAFE_1234, 32'h0F0F_5A5A);
    run_stream(100);

    // All-zero seed goes back to UNSEEDED
    seed_valid = 1'b1;
    seed_in    = 32'h0;
    @(negedge clk);
    chk("zero_reseed_valid", 64'(rnd_valid), 64'd0);
    send_beat(32'h0);
    send_beat(32'h0);
    for (int i = 0; i < 4; i++) begin
      rnd_ready = 1'($urandom % 2);
      chk("zero_valid", 64'(rnd_valid), 64'd0);
      chk("zero_rnd_out", 64'(rnd_out), 64'd0);
      chk("zero_seed_ready", 64'(seed_ready), 64'd1);
      chk("zero_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    rnd_ready = 1'b0;
    chk("zero_words_kept", 64'(words_out), 64'(m_words));

    // Reset while in SEED_HI discards the low word and clears the count
    send_beat(32'hA5A5_0000);
    rst_n      = 1'b0;
    seed_valid = 1'b1;
    seed_in    = 32'h1111_2222;
    @(negedge clk);
    rst_n      = 1'b1;
    seed_valid = 1'b0;
    m_words    = '0;
    chk("midseed_rst_words", 64'(words_out), 64'd0);
    chk("midseed_rst_busy", 64'(busy), 64'd1);
    chk("midseed_rst_valid", 64'(rnd_valid), 64'd0);
    #1;
    chk("midseed_rst_seed_ready", 64'(seed_ready), 64'd1);
    send_beat(32'h0BAD_F00D);
    send_beat(32'h0000_0001);
    expect_first_word(32'h0BAD_F00D, 32'h0000_0001);
    run_stream(50);

    // Saturation of the transfer counter
    force dut.words_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.words_q;
    m_words = 32'hFFFF_FFFE;
    chk("sat_forced", 64'(words_out), 64'(m_words));
    rnd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("sat_word", 64'(rnd_out), 64'(m_word));
      @(negedge clk);
      count_xfer();
      draw_word();
    end
    rnd_ready = 1'b0;
    chk("sat_words", 64'(words_out), 64'hFFFF_FFFF);
    chk("sat_model", 64'(words_out), 64'(m_words));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
